alarm_tone_gen: RTL

ALARM_TONE_GEN -- requirements
Module: alarm_tone_gen

---
 rtl/alarm_pkg.sv | 21 ++
 rtl/tone_divider.sv | 42 ++++
 rtl/alarm_tone_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types for the alarm tone generator: pattern mode encoding and FSM states.
package alarm_pkg;

    typedef enum logic [1:0] {
        MODE_CONT   = 2'd0,
        MODE_BEEP   = 2'd1,
        MODE_TRIPLE = 2'd2,
        MODE_SILENT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Beep index (0-based) of the last beep in a triple
    localparam logic [1:0] TRIPLE_LAST = 2'd2;

endpackage

// File: rtl/tone_divider.sv
// Half-period counter producing the buzzer square wave; restarts high on request,
// parks low with a cleared counter whenever it is not enabled.
module tone_divider #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             restart,
    input  logic [DIV_W-1:0] tone_div,
    output logic             wave
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_wave;
    logic [DIV_W-1:0] w_reload;

    // Effective half-period is max(tone_div,1); the counter holds half-period minus one
    assign w_reload = (tone_div == '0) ? '0 : tone_div - DIV_W'(1);
    assign wave     = r_wave;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (restart) begin
            r_cnt  <= w_reload;
            r_wave <= 1'b1;
        end else if (enable) begin
            if (r_cnt == '0) begin
                r_cnt  <= w_reload;
                r_wave <= ~r_wave;
            end else begin
                r_cnt <= r_cnt - DIV_W'(1);
            end
        end else begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end
    end

endmodule

// File: rtl/alarm_tone_gen.sv
// Alarm tone generator: pattern FSM (continuous / beep / triple / silent) gating
// a tone_divider square wave onto the buzzer output.
module alarm_tone_gen
    import alarm_pkg::*;
#(
    parameter int DIV_W        = 24,
    parameter int PAT_W        = 16,
    parameter int BEEP_ON_CYC  = 1000,
    parameter int BEEP_OFF_CYC = 1000,
    parameter int GAP_CYC      = 4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alarm_active,
    input  logic [DIV_W-1:0] tone_div,
    input  logic [1:0]       mode,
    output logic             buzzer,
    output logic             sounding
);

    localparam logic [PAT_W-1:0] ON_LD  = PAT_W'(BEEP_ON_CYC - 1);
    localparam logic [PAT_W-1:0] OFF_LD = PAT_W'(BEEP_OFF_CYC - 1);
    localparam logic [PAT_W-1:0] GAP_LD = PAT_W'(GAP_CYC - 1);

    state_e           r_state;
    mode_e            r_mode;
    logic [PAT_W-1:0] r_timer;
    logic [1:0]       r_beep_cnt;
    logic             r_sounding;

    logic w_timer_done;
    logic w_enter_on;
    logic w_stay_on;

    assign w_timer_done = (r_timer == '0);

    // Tone restarts on every ON entry and runs only while ON persists past this edge
    assign w_enter_on = alarm_active &&
        (((r_state == ST_IDLE) && (mode != MODE_SILENT)) ||
         ((((r_state == ST_OFF) && (r_mode != MODE_SILENT)) || (r_state == ST_GAP)) && w_timer_done));
    assign w_stay_on = alarm_active && (r_state == ST_ON) &&
        ((r_mode == MODE_CONT) || !w_timer_done);

    tone_divider #(
        .DIV_W (DIV_W)
    ) u_tone (
        .clk      (clk),
        .rst      (rst),
        .enable   (w_stay_on),
        .restart  (w_enter_on),
        .tone_div (tone_div),
        .wave     (buzzer)
    );

    assign sounding = r_sounding;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_CONT;
            r_timer    <= '0;
            r_beep_cnt <= '0;
            r_sounding <= 1'b0;
        end else if ((r_state != ST_IDLE) && !alarm_active) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_beep_cnt <= '0;
            r_sounding <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (alarm_active) begin
                        r_mode     <= mode_e'(mode);
                        r_beep_cnt <= '0;
                        if (mode == MODE_SILENT) begin
                            r_state    <= ST_OFF;
                            r_timer    <= '0;
                            r_sounding <= 1'b0;
                        end else begin
                            r_state    <= ST_ON;
                            r_timer    <= ON_LD;
                            r_sounding <= 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    if (r_mode == MODE_CONT) begin
                        r_timer <= '0;
                    end else if (w_timer_done) begin
                        r_sounding <= 1'b0;
                        if ((r_mode == MODE_TRIPLE) && (r_beep_cnt == TRIPLE_LAST)) begin
                            r_state    <= ST_GAP;
                            r_timer    <= GAP_LD;
                            r_beep_cnt <= '0;
                        end else begin
                            r_state    <= ST_OFF;
                            r_timer    <= OFF_LD;
                            r_beep_cnt <= (r_mode == MODE_TRIPLE) ? r_beep_cnt + 2'd1 : 2'd0;
                        end
                    end else begin
                        r_timer <= r_timer - PAT_W'(1);
                    end
                end
                ST_OFF, ST_GAP: begin
                    if ((r_state == ST_OFF) && (r_mode == MODE_SILENT)) begin
                        r_timer <= '0;
                    end else if (w_timer_done) begin
                        r_state    <= ST_ON;
                        r_timer    <= ON_LD;
                        r_sounding <= 1'b1;
                    end else begin
                        r_timer <= r_timer - PAT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
